isq: RTL and testbench
======================

# isq

Instruction sequencer: holds the instruction register (opcode plus up to two operand bytes) and the microcode step counter that together index the microcode decoder. Sits directly upstream of the decoder block (`db`) and consumes `db`'s fetch and sequencing controls: `ir_we`, `pc_lrc`, `pc_ini`, `pc_cub`, `trap` and `len`. Also detects sequencing faults and counts retired instructions.

## Interface
- `STEPS`, 8: microcode steps per opcode; `is` is clog2(STEPS) bits wide.
- `RET_W`, 16: width of the retired-instruction counter.

- `clk`  in  1  system clock; all state changes on posedge.
- `rst`  in  1  synchronous, active-low reset (asserted when 0).
- `bus_d`  in  8  data bus byte, captured when `ir_we` is set.
- `ir_we`  in  1  write the bus byte into the next IR slot.
- `pc_lrc`  in  1  jump/load: new instruction; clear `is` and the slot pointer.
- `pc_ini`  in  1  next instruction: clear `is` and the slot pointer.
- `pc_cub`  in  1  advance to the next microcode step.
- `trap`  in  1  decoder trap request.
- `len`  in  2  byte length of the current instruction, 1..3; 0 is illegal.
- `resume`  in  1  leave HALT.
- `insn`  out  8  opcode byte (IR slot 0).
- `d1`  out  8  first operand byte (IR slot 1).
- `d2`  out  8  second operand byte (IR slot 2).
- `is`  out  clog2(STEPS)  current microcode step.
- `halted`  out  1  the block is in HALT.
- `fault`  out  2  fault code: 0 none, 1 trap, 2 step overflow, 3 IR overflow or length error.
- `retired`  out  RET_W  count of completed instructions.

## Operation
- FSM has two states, RUN and HALT. Reset state is RUN.
- Reset values: `insn`=8'h00 (NOP), `d1`=`d2`=0, `is`=0, slot pointer `ptr`=0, `halted`=0, `fault`=0, `retired`=0.
- RUN, per cycle, highest priority first:
  - `trap`: go to HALT, `fault`=1.
  - `pc_lrc` or `pc_ini`: set `is`=0 and `ptr`=0, and increment `retired` (wraps modulo 2^RET_W). If `ptr` < `len` or `len`==0, also go to HALT with `fault`=3. Any `ir_we` or `pc_cub` in the same cycle is ignored.
  - `pc_cub`: `is`+1. If `is`==STEPS-1, go to HALT with `fault`=2 instead and leave `is` unchanged.
  - `ir_we`: write `bus_d` into slot `ptr`, then `ptr`+1. If `ptr`==3, drop the write and go to HALT with `fault`=3. `ir_we` and `pc_cub` together are legal: both take effect.
- HALT:
  - All of `ir_we`, `pc_*` and `trap` are ignored; IR, `is` and `retired` hold.
  - `resume`: go to RUN with `is`=0, `ptr`=0, `fault`=0. IR contents are retained.
- `fault` holds its value until `resume` or reset. Once HALT is entered, the first fault is kept.

## Timing
- Every output is registered. A control sampled at posedge N is visible just after posedge N.
- `db` samples `insn`/`is` on the negedge, so new values reach `db` half a cycle after they are updated. The fetch-to-decode latency is 0.5 cycle.
- `ir_we` write: the new byte appears on `insn`/`d1`/`d2` one edge later.
- Trap to `halted`: 1 cycle. `resume` to RUN: 1 cycle.
- Reset taken mid-instruction or in HALT: on the next posedge every output returns to its reset value. Reset overrides all other inputs.

## Structure
- Shared package `isq_pkg` holds:
  - the state typedef (RUN, HALT);
  - the fault enum (FLT_NONE, FLT_TRAP, FLT_STEP, FLT_IR);
  - the default `STEPS`.
- Also add `isq_pkg` to the decoder's include path so both blocks share the step width.
- One natural sub-module, `isq_step_ctr`: the step counter with clear, increment and overflow flag. All other logic stays inline.

## Test plan
- Fetch a three-byte instruction: release reset; pulse `ir_we` with bus 8'h12, 8'h34, 8'h56 while pulsing `pc_cub` each cycle; then `pc_ini` with `len`=3 -> `insn`=12, `d1`=34, `d2`=56, `is` reads 1, 2, 3, then 0, `retired`=1, `fault`=0.
- Step overflow: issue 8 consecutive `pc_cub` -> `halted`=1, `fault`=2, `is`=7.
- IR overflow: issue 4 `ir_we` without `pc_ini` -> the 4th byte is dropped, `fault`=3, `d2` holds the 3rd byte.
- Length error: with `len`=2 and one byte loaded, assert `pc_ini` -> `fault`=3, `retired`=1.
- Priority: assert `trap`, `pc_ini` and `ir_we` together -> `fault`=1, `retired` unchanged, IR unchanged. Then `resume` -> `halted`=0, `fault`=0, `is`=0.
- Reset mid-fetch: drive `rst`=0 after 2 bytes are loaded -> next cycle all outputs are 0.

Source files
------------

// File: rtl/isq_pkg.sv
// isq shared types: FSM state, fault codes, default sizes.
// Imported by the sequencer and by the decoder for the step width.
package isq_pkg;

  typedef enum logic {
    S_RUN,
    S_HALT
  } isq_state_e;

  typedef enum logic [1:0] {
    FLT_NONE = 2'd0,
    FLT_TRAP = 2'd1,
    FLT_STEP = 2'd2,
    FLT_IR   = 2'd3
  } isq_fault_e;

  localparam int STEPS_DEF = 8;
  localparam int RET_W_DEF = 16;

endpackage

// File: rtl/isq_step_ctr.sv
// Microcode step counter: sync clear, saturating-free increment,
// overflow flag raised while sitting on the last step.
module isq_step_ctr
  import isq_pkg::*;
#(
  parameter  int STEPS = STEPS_DEF,
  localparam int W     = $clog2(STEPS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         ovf_o
);

  localparam logic [W-1:0] LAST = W'(STEPS - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign ovf_o = (cnt_q == LAST);

endmodule

// File: rtl/isq.sv
// Instruction sequencer: IR slots, microcode step, fault
// detection and retired-instruction count.
module isq
  import isq_pkg::*;
#(
  parameter  int STEPS = STEPS_DEF,
  parameter  int RET_W = RET_W_DEF,
  localparam int IW    = $clog2(STEPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       bus_d,
  input  logic             ir_we,
  input  logic             pc_lrc,
  input  logic             pc_ini,
  input  logic             pc_cub,
  input  logic             trap,
  input  logic [1:0]       len,
  input  logic             resume,
  output logic [7:0]       insn,
  output logic [7:0]       d1,
  output logic [7:0]       d2,
  output logic [IW-1:0]    is,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [RET_W-1:0] retired
);

  isq_state_e       st_q, st_d;
  isq_fault_e       flt_q, flt_d;
  logic [7:0]       insn_q, insn_d;
  logic [7:0]       d1_q, d1_d;
  logic [7:0]       d2_q, d2_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [RET_W-1:0] ret_q, ret_d;

  logic clr, inc, ovf;
  logic step_flt, ir_flt;

  isq_step_ctr #(.STEPS(STEPS)) u_step (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .inc_i (inc),
    .cnt_o (is),
    .ovf_o (ovf)
  );

  always_comb begin
    st_d     = st_q;
    flt_d    = flt_q;
    insn_d   = insn_q;
    d1_d     = d1_q;
    d2_d     = d2_q;
    ptr_d    = ptr_q;
    ret_d    = ret_q;
    clr      = 1'b0;
    inc      = 1'b0;
    step_flt = pc_cub & ovf;
    ir_flt   = ir_we & (ptr_q == 2'd3);
    unique case (st_q)
      S_RUN: begin
        if (trap) begin
          st_d  = S_HALT;
          flt_d = FLT_TRAP;
        end else if (pc_lrc || pc_ini) begin
          clr   = 1'b1;
          ptr_d = '0;
          ret_d = ret_q + 1'b1;
          if (len == 2'd0 || ptr_q < len) begin
            st_d  = S_HALT;
            flt_d = FLT_IR;
          end
        end else begin
          inc = pc_cub & ~ovf;
          if (ir_we && !ir_flt) begin
            ptr_d = ptr_q + 1'b1;
            unique case (ptr_q)
              2'd0:    insn_d = bus_d;
              2'd1:    d1_d   = bus_d;
              default: d2_d   = bus_d;
            endcase
          end
          // A step overflow outranks an IR overflow raised alongside it.
          if (step_flt) begin
            st_d  = S_HALT;
            flt_d = FLT_STEP;
          end else if (ir_flt) begin
            st_d  = S_HALT;
            flt_d = FLT_IR;
          end
        end
      end
      default: begin
        if (resume) begin
          st_d  = S_RUN;
          flt_d = FLT_NONE;
          clr   = 1'b1;
          ptr_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q   <= S_RUN;
      flt_q  <= FLT_NONE;
      insn_q <= 8'h00;
      d1_q   <= 8'h00;
      d2_q   <= 8'h00;
      ptr_q  <= '0;
      ret_q  <= '0;
    end else begin
      st_q   <= st_d;
      flt_q  <= flt_d;
      insn_q <= insn_d;
      d1_q   <= d1_d;
      d2_q   <= d2_d;
      ptr_q  <= ptr_d;
      ret_q  <= ret_d;
    end
  end

  assign insn    = insn_q;
  assign d1      = d1_q;
  assign d2      = d2_q;
  assign halted  = (st_q == S_HALT);
  assign fault   = flt_q;
  assign retired = ret_q;

endmodule

// File: tb/tb_isq.sv
// Self-checking bench for isq: directed scenarios plus random
// traffic against a behavioural model.
module tb_isq;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bus_d;
  logic       ir_we, pc_lrc, pc_ini, pc_cub, trap, resume;
  logic [1:0] len;
  logic [7:0] insn, d1, d2;
  logic [2:0] is_w;
  logic       halted;
  logic [1:0] fault;
  logic [15:0] retired;

  int n_cmp = 0;
  int n_bad = 0;

  int m_ir[3];
  int m_ptr, m_is, m_halt, m_fault, m_ret;

  always #5 clk = ~clk;

  isq dut (
    .clk     (clk),
    .rst     (rst),
    .bus_d   (bus_d),
    .ir_we   (ir_we),
    .pc_lrc  (pc_lrc),
    .pc_ini  (pc_ini),
    .pc_cub  (pc_cub),
    .trap    (trap),
    .len     (len),
    .resume  (resume),
    .insn    (insn),
    .d1      (d1),
    .d2      (d2),
    .is      (is_w),
    .halted  (halted),
    .fault   (fault),
    .retired (retired)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    bus_d  = 8'h00;
    ir_we  = 1'b0;
    pc_lrc = 1'b0;
    pc_ini = 1'b0;
    pc_cub = 1'b0;
    trap   = 1'b0;
    resume = 1'b0;
    len    = 2'd0;
  endtask

  // Reference: applies the sequencing rules to the current inputs.
  task automatic model_step();
    bit lrc, sf, irf;
    lrc = pc_lrc || pc_ini;
    if (!rst) begin
      m_ir = '{0, 0, 0};
      m_ptr = 0; m_is = 0; m_halt = 0; m_fault = 0; m_ret = 0;
    end else if (m_halt == 0) begin
      if (trap) begin
        m_halt = 1; m_fault = 1;
      end else if (lrc) begin
        m_ret = (m_ret + 1) % 65536;
        if (len == 0 || m_ptr < int'(len)) begin
          m_halt = 1; m_fault = 3;
        end
        m_is = 0; m_ptr = 0;
      end else begin
        sf  = pc_cub && m_is == 7;
        irf = ir_we && m_ptr == 3;
        if (pc_cub && !sf) m_is++;
        if (ir_we && !irf) begin
          m_ir[m_ptr] = bus_d;
          m_ptr++;
        end
        if (sf) begin
          m_halt = 1; m_fault = 2;
        end else if (irf) begin
          m_halt = 1; m_fault = 3;
        end
      end
    end else if (resume) begin
      m_halt = 0; m_fault = 0; m_is = 0; m_ptr = 0;
    end
  endtask

  task automatic check_all();
    chk("insn", insn, m_ir[0]);
    chk("d1", d1, m_ir[1]);
    chk("d2", d2, m_ir[2]);
    chk("is", is_w, m_is);
    chk("halted", halted, m_halt);
    chk("fault", fault, m_fault);
    chk("retired", retired, m_ret);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic wr(input logic [7:0] b, input logic cub);
    idle();
    ir_we = 1'b1; bus_d = b; pc_cub = cub;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    do_reset();
    chk("rst_insn", insn, 0);
    chk("rst_is", is_w, 0);
    chk("rst_halted", halted, 0);
    chk("rst_ret", retired, 0);

    wr(8'h12, 1'b1); chk("f3_is1", is_w, 1);
    wr(8'h34, 1'b1); chk("f3_is2", is_w, 2);
    wr(8'h56, 1'b1); chk("f3_is3", is_w, 3);
    idle(); pc_ini = 1'b1; len = 2'd3; tick();
    chk("f3_insn", insn, 8'h12);
    chk("f3_d1", d1, 8'h34);
    chk("f3_d2", d2, 8'h56);
    chk("f3_is0", is_w, 0);
    chk("f3_ret", retired, 1);
    chk("f3_fault", fault, 0);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle(); pc_cub = 1'b1; tick();
    end
    chk("so_halted", halted, 1);
    chk("so_fault", fault, 2);
    chk("so_is", is_w, 7);

    do_reset();
    wr(8'ha1, 1'b0); wr(8'ha2, 1'b0);
    wr(8'ha3, 1'b0); wr(8'ha4, 1'b0);
    chk("io_fault", fault, 3);
    chk("io_d2", d2, 8'ha3);
    chk("io_insn", insn, 8'ha1);

    do_reset();
    wr(8'hb1, 1'b0);
    idle(); pc_ini = 1'b1; len = 2'd2; tick();
    chk("le_fault", fault, 3);
    chk("le_ret", retired, 1);

    do_reset();
    wr(8'h77, 1'b0);
    idle(); trap = 1'b1; pc_ini = 1'b1; len = 2'd1;
    ir_we = 1'b1; bus_d = 8'h99; tick();
    chk("pr_fault", fault, 1);
    chk("pr_ret", retired, 0);
    chk("pr_insn", insn, 8'h77);
    chk("pr_d1", d1, 0);
    idle(); resume = 1'b1; tick();
    chk("pr_halted", halted, 0);
    chk("pr_fault0", fault, 0);
    chk("pr_is", is_w, 0);

    wr(8'hc1, 1'b1); wr(8'hc2, 1'b1);
    idle(); rst = 1'b0; tick(); rst = 1'b1;
    chk("rm_insn", insn, 0);
    chk("rm_d1", d1, 0);
    chk("rm_is", is_w, 0);
    chk("rm_ret", retired, 0);

    for (int i = 0; i < 3000; i++) begin
      idle();
      rst    = ($urandom_range(0, 99) != 0);
      bus_d  = 8'($urandom);
      ir_we  = ($urandom_range(0, 2) == 0);
      pc_cub = ($urandom_range(0, 2) == 0);
      pc_ini = ($urandom_range(0, 5) == 0);
      pc_lrc = ($urandom_range(0, 11) == 0);
      trap   = ($urandom_range(0, 39) == 0);
      resume = ($urandom_range(0, 3) == 0);
      len    = 2'($urandom_range(0, 3));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
